// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator.
//   - imm_src_t and the IMM_* format codes
//   - imm_decode(): builds the immediate for a given format and width.
//     Returns {illegal, imm[63:0]}; callers keep the low XLEN bits.
package imm_pkg;

  localparam int unsigned XLEN_MAX = 64;

  typedef logic [2:0] imm_src_t;

  localparam imm_src_t IMM_I = 3'b000;
  localparam imm_src_t IMM_S = 3'b001;
  localparam imm_src_t IMM_B = 3'b010;
  localparam imm_src_t IMM_U = 3'b011;
  localparam imm_src_t IMM_J = 3'b100;
  localparam imm_src_t IMM_Z = 3'b101;

  // instr carries instruction bits [31:7]; the local copy keeps the
  // architectural bit numbering so the format fields read like the ISA manual.
  function automatic logic [XLEN_MAX:0] imm_decode(input logic [24:0]  instr,
                                                   input imm_src_t     imm_src,
                                                   input int unsigned  xlen);
    logic [31:7]         i;
    logic [XLEN_MAX-1:0] imm;
    logic                illegal;
    i       = instr;
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:   imm = {{52{i[31]}}, i[31:20]};
      IMM_S:   imm = {{52{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm = {{32{i[31]}}, i[31:12], 12'b0};
      IMM_J:   imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_Z:   imm = {59'b0, i[19:15]};
      default: illegal = 1'b1;
    endcase
    if (xlen == 32) begin
      imm[63:32] = '0;
    end
    return {illegal, imm};
  endfunction

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Bus bundle for imm_ext_pipe: decode-side input stream, execute-side output
// stream and the illegal-code counter.
//   master: the surrounding pipeline (drives inputs, consumes outputs)
//   slave : imm_ext_pipe itself
interface imm_ext_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 8
);
  import imm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [24:0]      instr;
  imm_src_t         imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, instr, imm_src, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal, err_cnt
  );

  modport slave (
    input  in_valid, instr, imm_src, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal, err_cnt
  );

endinterface

// File: rtl/imm_skid_buf.sv
// Generic valid/ready register slice: one output register plus one skid entry.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_ready depends only on state
//   in_data             payload
//   out_valid/out_ready downstream handshake, out_data held until accepted
module imm_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_fire;

  // Registered ready: the skid entry absorbs the beat accepted in the same
  // cycle the output stalls, so out_ready never reaches in_ready.
  assign in_ready = rst_n & ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_data_d   = out_data_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready) begin
      // Output slot frees up: oldest beat (skid first) moves in.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_data_d  = in_data;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate generator on the decode->execute boundary.
//   clk, rst_n  clock, synchronous active-low reset
//   bus         imm_ext_pipe_if slave: instr/imm_src/in_tag in, out_imm/out_tag/
//               out_illegal out (valid/ready both sides), err_cnt saturating
//               count of accepted illegal imm_src beats
// One cycle latency; decode is combinational ahead of the register slice.
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  imm_ext_pipe_if.slave bus
);

  localparam int unsigned W = 1 + TAG_W + XLEN;

  logic [XLEN_MAX:0] dec;
  logic [W-1:0]      in_data;
  logic [W-1:0]      out_data;
  logic              in_fire;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  assign dec     = imm_decode(bus.instr, bus.imm_src, XLEN);
  assign in_data = {dec[XLEN_MAX], bus.in_tag, dec[XLEN-1:0]};
  assign in_fire = bus.in_valid & bus.in_ready;

  if (XLEN < XLEN_MAX) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^dec[XLEN_MAX-1:XLEN];
  end

  imm_skid_buf #(
    .WIDTH (W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_data)
  );

  assign {bus.out_illegal, bus.out_tag, bus.out_imm} = out_data;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_fire && dec[XLEN_MAX] && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_ext_pipe_if #(.XLEN(32), .TAG_W(8), .CNT_W(8)) bus ();
  imm_ext_pipe_if #(.XLEN(64), .TAG_W(8), .CNT_W(2)) bus64 ();

  imm_ext_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  imm_ext_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(2)) u_dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        ill;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    err_model = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned fld(input longint unsigned x, input int lo, input int len);
    return (x >> lo) & ((64'd1 << len) - 64'd1);
  endfunction

  // Reference: assemble the field value arithmetically, then apply two's
  // complement interpretation of its top bit.
  function automatic beat_t ref_beat(input logic [31:0] ins, input logic [2:0] src,
                                     input logic [7:0] tag, input int xlen);
    longint unsigned x, u;
    int              w;
    beat_t           b;
    x = 64'(ins);
    u = 0;
    w = 0;
    b.tag = tag;
    b.ill = 1'b0;
    case (src)
      3'd0: begin u = fld(x, 20, 12); w = 12; end
      3'd1: begin u = (fld(x, 25, 7) << 5) | fld(x, 7, 5); w = 12; end
      3'd2: begin
        u = (fld(x, 31, 1) << 12) | (fld(x, 7, 1) << 11) | (fld(x, 25, 6) << 5)
            | (fld(x, 8, 4) << 1);
        w = 13;
      end
      3'd3: begin u = fld(x, 12, 20) << 12; w = 32; end
      3'd4: begin
        u = (fld(x, 31, 1) << 20) | (fld(x, 12, 8) << 12) | (fld(x, 20, 1) << 11)
            | (fld(x, 21, 10) << 1);
        w = 21;
      end
      3'd5: begin u = fld(x, 15, 5); w = 0; end
      default: b.ill = 1'b1;
    endcase
    if (w != 0 && fld(u, w - 1, 1) != 0) u = u - (64'd1 << w);
    if (xlen == 32) u = u & 64'hFFFF_FFFF;
    b.imm = u;
    return b;
  endfunction

  // Scoreboard and stability monitor for the 32-bit instance; all signals
  // change just after posedge, so the negedge sees what the next edge samples.
  beat_t prev;
  logic  prev_hold = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    beat_t n;
    if (!rst_n) begin
      sb.delete();
      err_model = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(bus.out_valid), 1);
        check("hold_imm", 64'(bus.out_imm), prev.imm);
        check("hold_tag", 64'(bus.out_tag), 64'(prev.tag));
        check("hold_ill", 64'(bus.out_illegal), 64'(prev.ill));
      end
      if (bus.out_valid && bus.out_ready) begin
        check("beat_expected", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_imm", 64'(bus.out_imm), e.imm);
          check("sb_tag", 64'(bus.out_tag), 64'(e.tag));
          check("sb_ill", 64'(bus.out_illegal), 64'(e.ill));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        n = ref_beat({bus.instr, 7'b0}, bus.imm_src, bus.in_tag, 32);
        sb.push_back(n);
        if (n.ill && err_model < 255) err_model++;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev.imm  = 64'(bus.out_imm);
      prev.tag  = bus.out_tag;
      prev.ill  = bus.out_illegal;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] src, input logic [7:0] tag);
    bus.in_valid = 1'b1;
    bus.instr    = ins[31:7];
    bus.imm_src  = src;
    bus.in_tag   = tag;
  endtask

  logic [31:0] sw_ins[4] = '{32'hFE000EE3, 32'h123450B7, 32'h001000EF, 32'h000A8000};
  logic [2:0]  sw_src[4] = '{3'd2, 3'd3, 3'd4, 3'd5};
  logic [31:0] sw_exp[4] = '{32'hFFFFFFFC, 32'h12345000, 32'h00000800, 32'h00000015};

  initial begin
    logic [7:0]  got[$];
    logic [31:0] tmp;
    int          idx;
    int          accepted;
    logic        acc;
    logic        drop_done;

    bus.in_valid = 0; bus.instr = '0; bus.imm_src = '0; bus.in_tag = '0; bus.out_ready = 1;
    bus64.in_valid = 0; bus64.instr = '0; bus64.imm_src = '0; bus64.in_tag = '0;
    bus64.out_ready = 1;
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_out_imm", 64'(bus.out_imm), 0);
    check("rst_out_tag", 64'(bus.out_tag), 0);
    check("rst_out_ill", 64'(bus.out_illegal), 0);
    check("rst_err_cnt", 64'(bus.err_cnt), 0);
    check("rst_in_ready", 64'(bus.in_ready), 0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", 64'(bus.in_ready), 1);

    // 1: I-format, one cycle latency
    drive(32'hFFF00093, 3'd0, 8'h11);
    tick();
    bus.in_valid = 0;
    check("t1_valid", 64'(bus.out_valid), 1);
    check("t1_imm", 64'(bus.out_imm), 64'hFFFFFFFF);
    check("t1_tag", 64'(bus.out_tag), 64'h11);

    // 2: format sweep, back to back
    for (int k = 0; k < 4; k++) begin
      drive(sw_ins[k], sw_src[k], 8'h20 + 8'(k));
      tick();
      check("t2_imm", 64'(bus.out_imm), 64'(sw_exp[k]));
    end
    bus.in_valid = 0;
    tick();

    // 3: backpressure with four beats
    bus.out_ready = 0;
    idx = 0;
    drop_done = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc == 3) bus.out_ready = 1;
      if (idx < 4) drive(32'h00000013 | (32'(idx) << 20), 3'd0, 8'h30 + 8'(idx));
      else bus.in_valid = 0;
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_tag);
      tick();
      if (acc) idx++;
      if (idx == 2 && !bus.out_ready && !drop_done) begin
        check("t3_in_ready_drop", 64'(bus.in_ready), 0);
        drop_done = 1;
      end
    end
    check("t3_count", 64'(got.size()), 4);
    for (int k = 0; k < got.size() && k < 4; k++) begin
      check("t3_order", 64'(got[k]), 64'(8'h30 + 8'(k)));
    end

    // 4: illegal codes
    for (int k = 0; k < 3; k++) begin
      drive(32'hDEADBEEF, 3'b111, 8'h40 + 8'(k));
      tick();
      check("t4_imm", 64'(bus.out_imm), 0);
      check("t4_ill", 64'(bus.out_illegal), 1);
    end
    bus.in_valid = 0;
    check("t4_err_cnt", 64'(bus.err_cnt), 3);

    // XLEN=64 / CNT_W=2 instance
    tmp = 32'hFE000EE3;
    bus64.in_valid = 1; bus64.instr = tmp[31:7]; bus64.imm_src = 3'd2; bus64.in_tag = 8'h50;
    tick();
    check("b64_imm", bus64.out_imm, 64'hFFFFFFFFFFFFFFFC);
    check("b64_tag", 64'(bus64.out_tag), 64'h50);
    bus64.imm_src = 3'b111;
    repeat (5) tick();
    bus64.in_valid = 0;
    check("sat_err_cnt", 64'(bus64.err_cnt), 3);

    // 5: reset with output and skid both full
    bus.out_ready = 0;
    drive(32'h00500013, 3'd0, 8'h60);
    tick();
    drive(32'h00600013, 3'd0, 8'h61);
    tick();
    check("t5_full_in_ready", 64'(bus.in_ready), 0);
    check("t5_full_valid", 64'(bus.out_valid), 1);
    rst_n = 1'b0;
    tick();
    check("t5_rst_valid", 64'(bus.out_valid), 0);
    check("t5_rst_err_cnt", 64'(bus.err_cnt), 0);
    check("t5_rst_in_ready", 64'(bus.in_ready), 0);
    bus.in_valid = 0;
    bus.out_ready = 1;
    rst_n = 1'b1;
    tick();
    check("t5_rel_in_ready", 64'(bus.in_ready), 1);
    check("t5_rel_valid", 64'(bus.out_valid), 0);
    drive(32'h80000013, 3'd0, 8'h70);
    tick();
    bus.in_valid = 0;
    check("t5_fresh_valid", 64'(bus.out_valid), 1);
    check("t5_fresh_imm", 64'(bus.out_imm), 64'hFFFFF800);
    check("t5_fresh_tag", 64'(bus.out_tag), 64'h70);

    // 6: random traffic against the scoreboard
    accepted = 0;
    for (int cyc = 0; cyc < 60000 && accepted < 10000; cyc++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        drive($urandom, 3'($urandom_range(0, 7)), 8'($urandom));
      end else begin
        bus.in_valid = 0;
        bus.imm_src  = 3'b111;
        bus.instr    = 25'($urandom);
      end
      if (bus.in_valid && bus.in_ready) accepted++;
      tick();
    end
    check("t6_accepted", 64'(accepted), 10000);
    bus.in_valid = 0;
    bus.out_ready = 1;
    for (int k = 0; k < 8 && sb.size() != 0; k++) tick();
    check("t6_drain", 64'(sb.size()), 0);
    check("t6_err_cnt", 64'(bus.err_cnt), 64'(err_model));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
